// File: rtl/acc_cpu.sv
// Accumulator CPU: byte-wide program memory, one clock per FSM state; NOP 1 clk, HLT/undefined 1 clk, two-byte ops 3 clk.
// No backpressure: start is only honoured in IDLE and HALT.
module acc_cpu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              error
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_SUB = 8'h03;
  localparam logic [7:0] OP_STA = 8'h04;
  localparam logic [7:0] OP_JMP = 8'h05;
  localparam logic [7:0] OP_JZ  = 8'h06;
  localparam logic [7:0] OP_HLT = 8'hFF;

  typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_ARG, EXEC, HALT} state_t;

  logic [7:0] mem [0:DEPTH-1];

  state_t            state, state_nxt;
  logic [7:0]        opcode, opcode_nxt;
  logic [ADDR_W-1:0] operand, operand_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              error_nxt;
  logic              mem_we;

  logic [7:0]        cur_byte;
  logic [DATA_W-1:0] arg_ext;
  logic              two_byte;
  logic              is_nop;
  logic              is_hlt;

  assign cur_byte = mem[pc];
  assign arg_ext  = DATA_W'(mem[operand]);
  assign two_byte = (cur_byte >= OP_LDA) && (cur_byte <= OP_JZ);
  assign is_nop   = (cur_byte == OP_NOP);
  assign is_hlt   = (cur_byte == OP_HLT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = FETCH_OP;
      FETCH_OP: begin
        if (two_byte)    state_nxt = FETCH_ARG;
        else if (is_nop) state_nxt = FETCH_OP;
        else             state_nxt = HALT;
      end
      FETCH_ARG: state_nxt = EXEC;
      EXEC:      state_nxt = FETCH_OP;
      HALT:      if (start) state_nxt = FETCH_OP;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_nxt     = acc;
    pc_nxt      = pc;
    opcode_nxt  = opcode;
    operand_nxt = operand;
    error_nxt   = error;
    mem_we      = 1'b0;
    case (state)
      FETCH_OP: begin
        opcode_nxt = cur_byte;
        // An undefined opcode leaves pc pointing at the offending byte.
        if (two_byte || is_nop || is_hlt) pc_nxt = pc + ADDR_W'(1);
        else                              error_nxt = 1'b1;
      end
      FETCH_ARG: begin
        operand_nxt = ADDR_W'(cur_byte);
        pc_nxt      = pc + ADDR_W'(1);
      end
      EXEC: begin
        case (opcode)
          OP_LDA:  acc_nxt = arg_ext;
          OP_ADD:  acc_nxt = acc + arg_ext;
          OP_SUB:  acc_nxt = acc - arg_ext;
          OP_STA:  mem_we  = 1'b1;
          OP_JMP:  pc_nxt  = operand;
          OP_JZ:   if (acc == '0) pc_nxt = operand;
          default: ;
        endcase
      end
      HALT: begin
        if (start) begin
          acc_nxt   = '0;
          pc_nxt    = '0;
          error_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      pc      <= '0;
      opcode  <= '0;
      operand <= '0;
      error   <= 1'b0;
      halted  <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      pc      <= pc_nxt;
      opcode  <= opcode_nxt;
      operand <= operand_nxt;
      error   <= error_nxt;
      halted  <= (state_nxt == HALT);
    end
  end

  // Memory has no reset; the rst gate keeps an aborted STA from landing.
  always_ff @(posedge clk) begin
    if (mem_we && rst) mem[operand] <= acc[7:0];
  end

  assign result = acc;

endmodule

// File: tb/tb_acc_cpu.sv
// Directed bench for acc_cpu: default instance for programs and reset, ADDR_W=4 instance for pc wrap.
module tb_acc_cpu;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start4;
  logic [31:0] result;
  logic [7:0]  pc;
  logic        halted;
  logic        error;
  logic [31:0] result4;
  logic [3:0]  pc4;
  logic        halted4;
  logic        error4;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  acc_cpu #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .result(result), .pc(pc), .halted(halted), .error(error)
  );

  acc_cpu #(.DATA_W(32), .ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .result(result4), .pc(pc4), .halted(halted4), .error(error4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Counts edges from the one that samples start (1) to the one that raises halted.
  task automatic run(output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cycles = 1;
    @(negedge clk);
    start = 1'b0;
    while (!halted && cycles < 1000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    if (!halted) check("run_timeout", 64'd0, 64'd1);
  endtask

  task automatic load(input logic [7:0] prog [], input int base);
    for (int i = 0; i < prog.size(); i++) dut.mem[base + i] = prog[i];
  endtask

  initial begin
    logic [7:0] p [];
    logic saw_wrap;
    logic [3:0] prev_pc4;

    rst    = 1'b0;
    start  = 1'b0;
    start4 = 1'b0;
    for (int i = 0; i < 256; i++) dut.mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) dut4.mem[i] = 8'h00;
    #1;
    check("rst_result", result, 0);
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_error", error, 0);

    // Sum 1+2+3
    p = '{8'h01, 8'h10, 8'h02, 8'h11, 8'h02, 8'h12, 8'hFF};
    load(p, 0);
    p = '{8'h01, 8'h02, 8'h03};
    load(p, 16);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_pc", pc, 0);
    check("idle_halted", halted, 0);
    run(cyc);
    check("sum_cycles", cyc, 11);
    check("sum_result", result, 6);
    check("sum_error", error, 0);
    check("sum_pc", pc, 7);
    repeat (3) @(negedge clk);
    check("halt_hold_pc", pc, 7);
    check("halt_hold_result", result, 6);
    check("halt_hold_halted", halted, 1);

    // Underflow and store
    p = '{8'h01, 8'h10, 8'h03, 8'h11, 8'h04, 8'h20, 8'hFF};
    load(p, 0);
    p = '{8'h01, 8'h02};
    load(p, 16);
    run(cyc);
    check("uflow_result", result, 32'hFFFF_FFFF);
    check("uflow_mem20", dut.mem[32], 8'hFF);
    check("uflow_halted", halted, 1);
    check("uflow_pc", pc, 7);

    // Countdown loop: 3 SUB iterations then JZ exits to HLT at 8
    p = '{8'h01, 8'h10, 8'h03, 8'h11, 8'h06, 8'h08, 8'h05, 8'h02, 8'hFF};
    load(p, 0);
    p = '{8'h03, 8'h01};
    load(p, 16);
    run(cyc);
    check("loop_result", result, 0);
    check("loop_pc", pc, 9);
    check("loop_halted", halted, 1);
    check("loop_cycles", cyc, 29);

    // Undefined opcode, then restart into HLT
    dut.mem[0] = 8'h7E;
    run(cyc);
    check("undef_cycles", cyc, 2);
    check("undef_halted", halted, 1);
    check("undef_error", error, 1);
    check("undef_pc", pc, 0);
    check("undef_result", result, 0);
    dut.mem[0] = 8'hFF;
    run(cyc);
    check("hlt_error", error, 0);
    check("hlt_halted", halted, 1);
    check("hlt_pc", pc, 1);

    // Async reset during EXEC of STA 20h
    p = '{8'h01, 8'h10, 8'h04, 8'h20, 8'hFF};
    load(p, 0);
    dut.mem[16] = 8'hAA;
    dut.mem[32] = 8'h55;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_result", result, 32'hAA);
    check("pre_rst_pc", pc, 4);
    rst = 1'b0;
    #1;
    check("arst_result", result, 0);
    check("arst_pc", pc, 0);
    check("arst_halted", halted, 0);
    check("arst_error", error, 0);
    repeat (2) @(negedge clk);
    check("arst_mem20", dut.mem[32], 8'h55);
    check("arst_prog0", dut.mem[0], 8'h01);
    check("arst_prog2", dut.mem[2], 8'h04);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle_pc", pc, 0);
    check("post_rst_idle_halted", halted, 0);
    run(cyc);
    check("rerun_result", result, 32'hAA);
    check("rerun_mem20", dut.mem[32], 8'hAA);

    // 16-byte memory: JMP 3, two STAs clear the JMP bytes, NOPs wrap pc to the HLT at 2
    dut4.mem[0] = 8'h05;
    dut4.mem[1] = 8'h03;
    dut4.mem[2] = 8'hFF;
    dut4.mem[3] = 8'h04;
    dut4.mem[4] = 8'h00;
    dut4.mem[5] = 8'h04;
    dut4.mem[6] = 8'h01;
    saw_wrap = 1'b0;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start4 = 1'b0;
    prev_pc4 = pc4;
    while (!halted4 && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (prev_pc4 == 4'd15 && pc4 == 4'd0) saw_wrap = 1'b1;
      prev_pc4 = pc4;
    end
    check("wrap_halted", halted4, 1);
    check("wrap_pc", pc4, 3);
    check("wrap_seen", saw_wrap, 1);
    check("wrap_error", error4, 0);
    check("wrap_cycles", cyc, 22);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
